// File: rtl/fcn_pkg.sv
// Shared types and the post-scale helper for the FCN systolic MAC array.
package fcn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip;
  } sat_res_t;

  // Shift, optional ReLU, then clamp to a signed out_w-bit range.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int unsigned shift,
                                         input logic relu,
                                         input int unsigned out_w);
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t r;
    v = acc >>> shift;
    if (relu && v < 0) v = '0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.value = v;
    r.clip  = 1'b0;
    if (v > hi) begin
      r.value = hi;
      r.clip  = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fcn_mac_array_if.sv
// Input-vector and result-vector handshake bundle of the FCN MAC array.
interface fcn_mac_array_if #(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  // A beat transfers on a rising edge where valid & ready; the producer holds
  // its payload stable while valid is high and ready is low.
  logic                      cfg_relu;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [N_OUT*DATA_W-1:0]   in_weight;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_OUT*OUT_W-1:0]    out_data;
  logic                      out_sat;

  modport slave (
    input  cfg_relu, in_valid, in_data, in_weight, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output cfg_relu, in_valid, in_data, in_weight, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fcn_mac_cell.sv
// One systolic lane: x/valid stage register feeding the next lane, plus a
// gated multiply-accumulate with synchronous clear.
module fcn_mac_cell #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic                     v_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [DATA_W-1:0] x_o,
  output logic                     v_o,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W-1:0]   x_q;
  logic                       v_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(x_q) * (2*DATA_W)'(w_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (v_q) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      x_q   <= x_i;
      v_q   <= v_i;
      acc_q <= acc_d;
    end
  end

  assign x_o   = x_q;
  assign v_o   = v_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/fcn_mac_array.sv
// Skewed systolic MAC layer: y[j] = sum_k x[k]*w[j][k], post-scaled and held
// until the consumer accepts it. ACC_W must not exceed 64.
module fcn_mac_array
  import fcn_pkg::*;
#(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8
) (
  input  logic  clk,
  input  logic  rst,
  fcn_mac_array_if.slave bus,
  output state_e state_o
);

  localparam int CNT_W = $clog2(N_OUT + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    relu_q, relu_d;
  logic [N_OUT*OUT_W-1:0]  out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    clr;
  logic                    accept;

  logic signed [DATA_W-1:0] x_lane_in [N_OUT];
  logic                     v_lane_in [N_OUT];
  logic signed [DATA_W-1:0] x_nxt     [N_OUT];
  logic                     v_nxt     [N_OUT];
  logic signed [DATA_W-1:0] w_lane    [N_OUT];
  logic signed [ACC_W-1:0]  acc       [N_OUT];
  sat_res_t                 sr        [N_OUT];
  logic [N_OUT*OUT_W-1:0]   res_data;
  logic [N_OUT-1:0]         res_clip;
  logic [N_OUT-1:0]         sat_hi_unused;
  logic                     tail_unused;

  assign bus.in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept       = bus.in_valid && bus.in_ready;

  assign x_lane_in[0] = bus.in_data;
  assign v_lane_in[0] = accept;

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    // Weight for lane j sits j+1 registers deep, matching the j+1 x stages.
    logic signed [DATA_W-1:0] w_dl_q [j+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= j; d++) w_dl_q[d] <= '0;
      end else begin
        w_dl_q[0] <= bus.in_weight[j*DATA_W +: DATA_W];
        for (int d = 1; d <= j; d++) w_dl_q[d] <= w_dl_q[d-1];
      end
    end

    assign w_lane[j] = w_dl_q[j];

    fcn_mac_cell #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .clr_i(clr),
      .x_i  (x_lane_in[j]),
      .v_i  (v_lane_in[j]),
      .w_i  (w_lane[j]),
      .x_o  (x_nxt[j]),
      .v_o  (v_nxt[j]),
      .acc_o(acc[j])
    );

    if (j < N_OUT - 1) begin : g_link
      assign x_lane_in[j+1] = x_nxt[j];
      assign v_lane_in[j+1] = v_nxt[j];
    end else begin : g_tail
      assign tail_unused = ^{x_nxt[j], v_nxt[j]};
    end

    assign sr[j]        = sat_shift(64'(acc[j]), SHIFT, relu_q, OUT_W);
    assign res_data[j*OUT_W +: OUT_W] = sr[j].value[OUT_W-1:0];
    assign res_clip[j]  = sr[j].clip;
    assign sat_hi_unused[j] = ^sr[j].value[SAT_W-1:OUT_W];
  end

  // DRAIN runs N_OUT+1 cycles so the last lane's final MAC lands before capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    clr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          relu_d  = bus.cfg_relu;
          cnt_d   = '0;
          state_d = bus.in_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && bus.in_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(N_OUT)) begin
          out_data_d = res_data;
          out_sat_d  = |res_clip;
          state_d    = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fcn_mac_array.sv
// Bench for fcn_mac_array: two instances (SHIFT=0 and SHIFT=16) share one
// stimulus stream and are scored against an arithmetic reference model.
module tb_fcn_mac_array;
  import fcn_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int EW = N*OW + 1;

  logic clk;
  logic rst;
  int   cyc = 0;

  logic            cfg_relu;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [N*DW-1:0] in_weight;
  logic            in_last;
  logic            out_ready;
  state_e          st0, st1;

  fcn_mac_array_if #(.N_OUT(N), .DATA_W(DW), .OUT_W(OW)) bus0 ();
  fcn_mac_array_if #(.N_OUT(N), .DATA_W(DW), .OUT_W(OW)) bus1 ();

  assign bus0.cfg_relu  = cfg_relu;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_weight = in_weight;
  assign bus0.in_last   = in_last;
  assign bus0.out_ready = out_ready;
  assign bus1.cfg_relu  = cfg_relu;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_weight = in_weight;
  assign bus1.in_last   = in_last;
  assign bus1.out_ready = out_ready;

  fcn_mac_array #(.N_OUT(N), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_o(st0)
  );
  fcn_mac_array #(.N_OUT(N), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(16)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_o(st1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  int xs [16];
  int ws [16][N];
  int last_acc;
  int hs_cyc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Dot product per lane, wrapped to AW bits, then shift / ReLU / clamp.
  function automatic logic [EW-1:0] model(input int n, input int shift, input bit relu);
    logic [EW-1:0] r;
    longint acc, v, hi, lo;
    bit sat;
    r   = '0;
    sat = 1'b0;
    hi  = (longint'(1) <<< (OW - 1)) - 1;
    lo  = -hi - 1;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int k = 0; k < n; k++) acc += longint'(xs[k]) * longint'(ws[k][j]);
      acc = (acc <<< (64 - AW)) >>> (64 - AW);
      v = acc >>> shift;
      if (relu && v < 0) v = 0;
      if (v > hi) begin
        v = hi; sat = 1'b1;
      end else if (v < lo) begin
        v = lo; sat = 1'b1;
      end
      r[j*OW +: OW] = OW'(v);
    end
    r[EW-1] = sat;
    return r;
  endfunction

  task automatic push_expected(input int n, input bit relu);
    exp0_q.push_back(model(n, 0, relu));
    exp1_q.push_back(model(n, 16, relu));
  endtask

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic drive_vector(input int n, input bit relu, input int bubbles, input bit with_last);
    int guard;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k > 0 && (bubbles == 1 || (bubbles == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid = 1'b0;
        cfg_relu = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = DW'(xs[k]);
      for (int j = 0; j < N; j++) in_weight[j*DW +: DW] = DW'(ws[k][j]);
      in_last  = with_last && (k == n - 1);
      cfg_relu = (k == 0) ? relu : 1'($urandom_range(0, 1));
      guard = 0;
      while (!bus0.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    last_acc = cyc;
  endtask

  task automatic receive(input int hold);
    int guard;
    logic busy_ready;
    logic [EW-1:0] e0, e1;
    guard = 0;
    busy_ready = 1'b0;
    while (!bus0.out_valid && guard < 200) begin
      busy_ready |= bus0.in_ready | bus1.in_ready;
      @(negedge clk);
      guard++;
    end
    if (!bus0.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("latency", cyc - last_acc, N + 1);
    chk("drain_in_ready", busy_ready, 0);
    chk("out_state", st0, OUT);
    chk("out_in_ready", {bus0.in_ready, bus1.in_ready}, 0);
    if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
      chk("unexpected_result", 1, 0);
      return;
    end
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_y_shift0", {bus0.out_sat, bus0.out_data}, e0);
      chk("hold_valid_ready", {bus0.out_valid, bus0.in_ready}, 2'b10);
    end
    chk("y_shift0", {bus0.out_sat, bus0.out_data}, e0);
    chk("y_shift16", {bus1.out_sat, bus1.out_data}, e1);
    chk("sync_valid", bus1.out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    hs_cyc = cyc;
    chk("idle_ready_valid", {bus0.in_ready, bus0.out_valid}, 2'b10);
  endtask

  task automatic set_lanes_const(input int k, input int w);
    for (int j = 0; j < N; j++) ws[k][j] = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic seen;
    logic signed [DW-1:0] t;
    rst = 1'b1;
    cfg_relu = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {st0, st1}, {IDLE, IDLE});
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_data", {bus0.out_sat, bus0.out_data}, 0);

    // basic vector, lane j weight j+1
    for (int k = 0; k < 3; k++) begin
      xs[k] = k + 1;
      for (int j = 0; j < N; j++) ws[k][j] = j + 1;
    end
    push_expected(3, 1'b0);
    drive_vector(3, 1'b0, 0, 1'b1);
    receive(0);

    // same vector with alternating bubbles
    push_expected(3, 1'b0);
    drive_vector(3, 1'b0, 1, 1'b1);
    receive(2);

    // length-1 vector, ReLU on then off
    xs[0] = -3;
    ws[0][0] = 1; ws[0][1] = -1; ws[0][2] = 2; ws[0][3] = -2;
    push_expected(1, 1'b1);
    drive_vector(1, 1'b1, 0, 1'b1);
    receive(0);
    push_expected(1, 1'b0);
    drive_vector(1, 1'b0, 0, 1'b1);
    receive(0);

    // saturation corner
    for (int k = 0; k < 2; k++) begin
      xs[k] = 32767;
      set_lanes_const(k, 32767);
    end
    push_expected(2, 1'b0);
    drive_vector(2, 1'b0, 0, 1'b1);
    receive(0);

    // long hold, then back-to-back vector with cleared accumulators
    xs[0] = 5; xs[1] = -7;
    set_lanes_const(0, 3); set_lanes_const(1, 2);
    push_expected(2, 1'b0);
    drive_vector(2, 1'b0, 0, 1'b1);
    receive(10);
    xs[0] = 9;
    ws[0][0] = 1; ws[0][1] = 2; ws[0][2] = -3; ws[0][3] = 4;
    push_expected(1, 1'b0);
    drive_vector(1, 1'b0, 0, 1'b1);
    chk("next_accept_cycle", last_acc - hs_cyc, 1);
    receive(0);

    // reset in the middle of a vector
    xs[0] = 100; xs[1] = 200;
    set_lanes_const(0, 50); set_lanes_const(1, 60);
    drive_vector(2, 1'b0, 0, 1'b0);
    chk("pre_abort_state", st0, ACCUM);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_valid", {bus0.in_ready, bus0.out_valid}, 2'b10);
    chk("abort_state", st0, IDLE);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus0.out_valid | bus1.out_valid;
    end
    chk("abort_no_result", seen, 0);
    xs[0] = 1;
    set_lanes_const(0, 1);
    push_expected(1, 1'b0);
    drive_vector(1, 1'b0, 0, 1'b1);
    receive(0);

    // randomized vectors
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        if (v % 2 == 0) begin
          t = DW'($urandom_range(0, 65535));
          xs[k] = int'(t);
          for (int j = 0; j < N; j++) begin
            t = DW'($urandom_range(0, 65535));
            ws[k][j] = int'(t);
          end
        end else begin
          xs[k] = int'($urandom_range(0, 200)) - 100;
          for (int j = 0; j < N; j++) ws[k][j] = int'($urandom_range(0, 200)) - 100;
        end
      end
      seen = 1'($urandom_range(0, 1));
      push_expected(n, seen);
      drive_vector(n, seen, 2, 1'b1);
      receive($urandom_range(0, 3));
    end

    chk("leftover_expected", exp0_q.size() + exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
